tetris_game_fsm: RTL
====================

// Module: tetris_game_fsm
// PURPOSE
//  Top-level Tetris game sequencer, successor of the fixed 22-row game-logic FSM.
//  Sequences spawn -> fall -> lock -> row-clear for a board of ROWS rows.
//  Adds: a gravity timer, board-operation handshake, one-hot full-row selection,
//  a cleared-line counter, an explicit IDLE state and restartable HALT.
//  Sits between the input/timing logic and the board RAM/datapath, which executes
//  the op named by out_state and reports completion on board_done.
// PARAMETERS
//  ROWS        22        board rows; bit i of full_rows/shift_row = row i (0 = top)
//  DROP_TICKS  50000000  clk cycles per gravity step (>= 2)
//  LINE_W      16        width of lines_cleared counter
// PORTS
//  clk            in   1          system clock
//  reset          in   1          asynchronous, active-high reset
//  start          in   1          level; leaves IDLE, restarts from HALT
//  full_rows      in   ROWS       row i completely filled
//  collide_down   in   1          active piece cannot move one row down
//  spawn_blocked  in   1          newly spawned piece overlaps the board
//  soft_drop      in   1          level; forces a gravity step every MOVE cycle
//  board_done     in   1          1-cycle pulse: requested board op complete
//  out_state      out  3          current op code (decode of state register)
//  shift_row      out  ROWS       one-hot row to delete/shift down; 0 otherwise
//  move_down      out  1          1-cycle pulse: move active piece down one row
//  lines_cleared  out  LINE_W     total rows cleared, saturating
//  game_over      out  1          high while in HALT
// BEHAVIOUR
//  Encoding: CHECK=000 MOVE=001 WRITE=010 SHIFT=011 ADD=100 HALT=110 IDLE=111.
//  Reset (async, any state/mid-op): state=IDLE, out_state=111, shift_row=0,
//   move_down=0, lines_cleared=0, game_over=0, drop counter=0. Pending op abandoned.
//  All outputs registered or decoded from registers; all decisions use inputs
//   sampled at the rising clk edge ending the cycle.
//  IDLE : start=1 -> CHECK; else stay.
//  CHECK: full_rows!=0 -> SHIFT, shift_row <= one-hot of LOWEST-index set bit;
//         else -> ADD. One cycle.
//  SHIFT: hold shift_row; on board_done -> CHECK, shift_row<=0, lines_cleared+1
//         (holds at 2^LINE_W-1). Multiple full rows cleared one per CHECK/SHIFT pass.
//  ADD  : on board_done: spawn_blocked=1 -> HALT; else -> MOVE, counter<=0.
//  MOVE : counter increments each cycle. Step when counter==DROP_TICKS-1 or
//         soft_drop=1. On step: collide_down=1 -> WRITE (no move_down);
//         else move_down=1 next cycle only, counter<=0, stay in MOVE.
//         Non-step cycles: stay. soft_drop with collide_down -> WRITE immediately.
//  WRITE: on board_done -> CHECK (lock then clear).
//  HALT : game_over=1; start=1 -> IDLE, lines_cleared<=0, game_over<=0.
//  board_done outside ADD/SHIFT/WRITE ignored; ops wait indefinitely for it.
//  board_done and start in same cycle: only the current state's rule applies.
//  Illegal encodings (101) -> IDLE next cycle, outputs as reset.
// TESTING
//  Reset mid-SHIFT (shift_row=0x4) -> next cycle out_state=111, shift_row=0,
//   lines_cleared=0 regardless of board_done.
//  start, full_rows=0, board_done after 3 cyc -> 111,000,100(x3),001; counter=0.
//  DROP_TICKS=4, collide_down=0 in MOVE -> move_down pulses every 4 cycles,
//   width 1; soft_drop=1 -> pulse every cycle.
//  collide_down=1 at step -> WRITE(010); board_done -> CHECK; full_rows=0x00A
//   -> shift_row=0x002, then 0x008 on next pass; lines_cleared=2; then ADD.
//  ADD with spawn_blocked=1 at board_done -> out_state=110, game_over=1 held;
//   start -> IDLE, game_over=0, lines_cleared=0.
//  LINE_W=2, clear 5 rows -> lines_cleared saturates at 3.

Source files
------------

// File: rtl/tetris_game_fsm.sv
// Tetris game sequencer: spawn -> fall -> lock -> row-clear over a ROWS-row board.
// out_state names the board op in flight; the board datapath answers with board_done.
module tetris_game_fsm #(
    parameter int ROWS       = 22,
    parameter int DROP_TICKS = 50000000,
    parameter int LINE_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROWS-1:0]   full_rows,
    input  logic              collide_down,
    input  logic              spawn_blocked,
    input  logic              soft_drop,
    input  logic              board_done,
    output logic [2:0]        out_state,
    output logic [ROWS-1:0]   shift_row,
    output logic              move_down,
    output logic [LINE_W-1:0] lines_cleared,
    output logic              game_over
);

    localparam int CNT_W = $clog2(DROP_TICKS);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DROP_TICKS - 1);

    typedef enum logic [2:0] {
        CHECK = 3'b000,
        MOVE  = 3'b001,
        WRITE = 3'b010,
        SHIFT = 3'b011,
        ADD   = 3'b100,
        HALT  = 3'b110,
        IDLE  = 3'b111
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] drop_cnt;
    logic [ROWS-1:0]  lowest_full;
    logic             step;

    // Handshake: while in ADD, SHIFT or WRITE the op named by out_state is the
    // request, held until a one-cycle board_done pulse completes it; board_done
    // seen in any other state carries no meaning and is dropped.
    assign out_state = state;
    assign game_over = (state == HALT);

    // x & -x isolates the lowest set bit, i.e. the topmost full row.
    assign lowest_full = full_rows & (~full_rows + ROWS'(1));
    assign step        = (drop_cnt == LAST_TICK) || soft_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shift_row     <= '0;
            move_down     <= 1'b0;
            lines_cleared <= '0;
            drop_cnt      <= '0;
        end else begin
            move_down <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= CHECK;
                end
                CHECK: begin
                    if (full_rows != '0) begin
                        state     <= SHIFT;
                        shift_row <= lowest_full;
                    end else begin
                        state <= ADD;
                    end
                end
                SHIFT: begin
                    if (board_done) begin
                        state     <= CHECK;
                        shift_row <= '0;
                        if (lines_cleared != '1) lines_cleared <= lines_cleared + LINE_W'(1);
                    end
                end
                ADD: begin
                    if (board_done) begin
                        if (spawn_blocked) begin
                            state <= HALT;
                        end else begin
                            state    <= MOVE;
                            drop_cnt <= '0;
                        end
                    end
                end
                MOVE: begin
                    if (step) begin
                        if (collide_down) begin
                            state <= WRITE;
                        end else begin
                            move_down <= 1'b1;
                            drop_cnt  <= '0;
                        end
                    end else begin
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (board_done) state <= CHECK;
                end
                HALT: begin
                    if (start) begin
                        state         <= IDLE;
                        lines_cleared <= '0;
                    end
                end
                default: begin
                    // Unused encoding: recover exactly as from reset.
                    state         <= IDLE;
                    shift_row     <= '0;
                    lines_cleared <= '0;
                    drop_cnt      <= '0;
                end
            endcase
        end
    end

endmodule
